// File: rtl/mac_pe_stw_multi_pkg.sv
// Shared types for the multi-vector self-test PE: controller states, the
// test-vector record and the multiplier fault-injection helper.
package mac_stw_pkg;

    // Word width of a test-vector record. It sets the layout of the queue
    // entries, so the PE's WORD_SIZE must equal it.
    localparam int STW_WORD_SIZE = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stw_state_t;

    typedef struct packed {
        logic [STW_WORD_SIZE-1:0] mult_op1;
        logic [STW_WORD_SIZE-1:0] mult_op2;
        logic [STW_WORD_SIZE-1:0] add_op;
        logic [STW_WORD_SIZE-1:0] expected;
    } stw_tv_t;

    // Force the masked multiplier bits to the selected stuck-at level when
    // injection is enabled; otherwise pass the product through untouched.
    function automatic logic [STW_WORD_SIZE-1:0] fault_apply(
        input logic [STW_WORD_SIZE-1:0] mult,
        input logic [STW_WORD_SIZE-1:0] mask,
        input logic [1:0]               inj
    );
        logic [STW_WORD_SIZE-1:0] em;
        em = inj[0] ? mask : '0;
        return (mult & ~em) | (inj[1] ? em : '0);
    endfunction

endpackage

// File: rtl/mac_pe_stw_multi_if.sv
// Test-vector load and self-test control/status bundle between the array
// controller (master) and the PE (slave).
interface mac_pe_stw_multi_if #(
    parameter int WORD_SIZE = 16,
    parameter int TV_DEPTH  = 4
);
    localparam int FC_W  = $clog2(TV_DEPTH + 1);
    localparam int IDX_W = $clog2(TV_DEPTH);

    logic                 tv_valid;
    logic                 tv_ready;
    logic [WORD_SIZE-1:0] tv_mult_op1;
    logic [WORD_SIZE-1:0] tv_mult_op2;
    logic [WORD_SIZE-1:0] tv_add_op;
    logic [WORD_SIZE-1:0] tv_expected;
    logic                 stw_start;
    logic                 stw_busy;
    logic                 stw_done;
    logic                 stw_pass;
    logic [FC_W-1:0]      stw_fail_count;
    logic [IDX_W-1:0]     stw_first_fail_idx;

    modport master (
        output tv_valid, tv_mult_op1, tv_mult_op2, tv_add_op, tv_expected, stw_start,
        input  tv_ready, stw_busy, stw_done, stw_pass, stw_fail_count, stw_first_fail_idx
    );

    modport slave (
        input  tv_valid, tv_mult_op1, tv_mult_op2, tv_add_op, tv_expected, stw_start,
        output tv_ready, stw_busy, stw_done, stw_pass, stw_fail_count, stw_first_fail_idx
    );
endinterface

// File: rtl/mac_pe_stw_multi_tv_fifo.sv
// Synchronous test-vector FIFO; pointers wrap modulo DEPTH so any depth >= 2
// works. Push when full and pop when empty are dropped.
module stw_tv_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_pe_stw_multi.sv
// Systolic MAC PE with a multi-vector self-test window. In IDLE the PE runs
// its normal weight/input-stationary MAC; a start command drains the queued
// test vectors through the same multiplier/adder, one per cycle, while the
// datapath registers are frozen, and records pass/fail statistics.
module mac_pe_stw_multi
    import mac_stw_pkg::*;
#(
    parameter  int WORD_SIZE = STW_WORD_SIZE,
    parameter  int TV_DEPTH  = 4,
    localparam int FC_W      = $clog2(TV_DEPTH + 1),
    localparam int IDX_W     = $clog2(TV_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fsm_op2_select_in,
    input  logic                 fsm_out_select_in,
    input  logic                 stat_bit_in,
    input  logic [WORD_SIZE-1:0] left_in,
    input  logic [WORD_SIZE-1:0] top_in,
    output logic [WORD_SIZE-1:0] right_out,
    output logic [WORD_SIZE-1:0] bottom_out,
    input  logic [1:0]           fault_inject,
    input  logic [WORD_SIZE-1:0] fault_mask,
    mac_pe_stw_multi_if.slave    stw
);
    localparam int TV_W = $bits(stw_tv_t);

    stw_state_t state, state_next;

    // Queue signals
    stw_tv_t         push_tv, head_tv;
    logic [TV_W-1:0] fifo_rd;
    logic            fifo_full, fifo_empty;
    logic [FC_W-1:0] fifo_count;
    logic            push, pop, run, last, start_run;

    // Datapath
    logic [WORD_SIZE-1:0] left_in_reg, top_in_reg, acc_reg, stat_reg;
    logic [WORD_SIZE-1:0] op_a, op_b, add_op, mult, mult_f, adder_out;
    logic                 mismatch;

    // Results
    logic             pass_q, done_q;
    logic [FC_W-1:0]  fail_cnt_q;
    logic [IDX_W-1:0] first_idx_q, run_idx;

    assign push_tv = '{mult_op1: stw.tv_mult_op1, mult_op2: stw.tv_mult_op2,
                       add_op:   stw.tv_add_op,   expected: stw.tv_expected};
    assign head_tv = fifo_rd;

    assign run          = (state == RUN);
    assign stw.tv_ready = !run && !fifo_full;
    assign push         = stw.tv_valid && stw.tv_ready;
    assign pop          = run;
    assign last         = run && (fifo_count == FC_W'(1));
    // A push landing with the start counts, so an empty queue plus a push
    // still launches a run.
    assign start_run    = !run && stw.stw_start && (!fifo_empty || push);

    stw_tv_fifo #(
        .WIDTH (TV_W),
        .DEPTH (TV_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (push_tv),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Operand selection: test mode feeds the queue head into the real MAC path.
    always_comb begin
        op_a   = left_in_reg;
        op_b   = stat_bit_in ? stat_reg : top_in_reg;
        add_op = stat_bit_in ? top_in_reg : acc_reg;
        if (run) begin
            op_a   = head_tv.mult_op1;
            op_b   = head_tv.mult_op2;
            add_op = head_tv.add_op;
        end
    end

    assign mult      = op_a * op_b;
    assign mult_f    = fault_apply(mult, fault_mask, fault_inject);
    assign adder_out = mult_f + add_op;
    assign mismatch  = (adder_out != head_tv.expected);

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state: launch on a qualified start, return after the last pop.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_run) state_next = RUN;
            RUN:     if (last)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; they hold for the whole run so array outputs stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_in_reg <= '0;
            top_in_reg  <= '0;
            acc_reg     <= '0;
            stat_reg    <= '0;
        end else if (!run) begin
            left_in_reg <= left_in;
            top_in_reg  <= top_in;
            acc_reg     <= adder_out;
            if (fsm_op2_select_in) stat_reg <= top_in;
        end
    end

    // Run statistics: cleared on launch, updated once per popped vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q      <= 1'b1;
            fail_cnt_q  <= '0;
            first_idx_q <= '0;
            run_idx     <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= run && last;
            if (start_run) begin
                pass_q      <= 1'b1;
                fail_cnt_q  <= '0;
                first_idx_q <= '0;
                run_idx     <= '0;
            end else if (run) begin
                run_idx <= run_idx + 1'b1;
                if (mismatch) begin
                    pass_q     <= 1'b0;
                    fail_cnt_q <= fail_cnt_q + 1'b1;
                    if (fail_cnt_q == '0) first_idx_q <= run_idx;
                end
            end
        end
    end

    assign right_out              = left_in_reg;
    assign bottom_out             = fsm_out_select_in ? acc_reg : top_in_reg;
    assign stw.stw_busy           = run;
    assign stw.stw_done           = done_q;
    assign stw.stw_pass           = pass_q;
    assign stw.stw_fail_count     = fail_cnt_q;
    assign stw.stw_first_fail_idx = first_idx_q;

endmodule
